// File: rtl/serial_adder_pkg.sv
// Shared constants for the bit-serial adder: state encoding and default operand width.
package serial_adder_pkg;

  localparam int unsigned DefaultWidth = 8;

  // 2'd3 is unused and recovers to StIdle.
  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

endpackage

// File: rtl/FA.sv
// Single-bit full adder, reused once per cycle by the serial adder.
module FA (
  input  logic a,
  input  logic b,
  input  logic c_in,
  output logic s,
  output logic c_out
);

  assign s     = a ^ b ^ c_in;
  assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one operand bit per cycle through a single full adder,
// with the carry held in a flop between cycles and a start/done handshake.
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out
);

  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr_q, a_sr_d;
  logic [WIDTH-1:0] b_sr_q, b_sr_d;
  logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
  logic             carry_q, carry_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             c_out_q, c_out_d;

  logic             fa_s;
  logic             fa_co;
  logic [WIDTH:0]   sum_cat;
  logic [WIDTH-1:0] sum_shift;
  logic             sr_lsb_unused;

  FA u_fa (
    .a     (a_sr_q[0]),
    .b     (b_sr_q[0]),
    .c_in  (carry_q),
    .s     (fa_s),
    .c_out (fa_co)
  );

  // New sum bit enters at the MSB; the oldest bit drops off the LSB end.
  assign sum_cat       = {fa_s, sum_sr_q};
  assign sum_shift     = sum_cat[WIDTH:1];
  assign sr_lsb_unused = sum_cat[0];

  // Next-state, datapath updates and operand capture.
  always_comb begin
    state_d  = state_q;
    a_sr_d   = a_sr_q;
    b_sr_d   = b_sr_q;
    sum_sr_d = sum_sr_q;
    carry_d  = carry_q;
    cnt_d    = cnt_q;
    sum_d    = sum_q;
    c_out_d  = c_out_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      StShift: begin
        a_sr_d   = a_sr_q >> 1;
        b_sr_d   = b_sr_q >> 1;
        sum_sr_d = sum_shift;
        carry_d  = fa_co;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntLast) begin
          sum_d   = sum_shift;
          c_out_d = fa_co;
          state_d = StDone;
        end
      end
      StDone: begin
        // Re-accepting start here gives back-to-back operation without an idle cycle.
        state_d = StIdle;
        if (start) begin
          a_sr_d  = a;
          b_sr_d  = b;
          carry_d = c_in;
          cnt_d   = '0;
          state_d = StShift;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      a_sr_q   <= '0;
      b_sr_q   <= '0;
      sum_sr_q <= '0;
      carry_q  <= 1'b0;
      cnt_q    <= '0;
      sum_q    <= '0;
      c_out_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sr_q   <= a_sr_d;
      b_sr_q   <= b_sr_d;
      sum_sr_q <= sum_sr_d;
      carry_q  <= carry_d;
      cnt_q    <= cnt_d;
      sum_q    <= sum_d;
      c_out_q  <= c_out_d;
    end
  end

  assign busy  = (state_q == StShift);
  assign done  = (state_q == StDone);
  assign sum   = sum_q;
  assign c_out = c_out_q;

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands plus carry-in over WIDTH clock cycles. It reuses the existing single-bit full adder once per cycle and keeps the carry in a flip-flop between cycles. It sits directly downstream of the operand switches/registers and directly upstream of the sum/carry LEDs, in place of a WIDTH-wide combinational chain. It also gives the team its first clocked arithmetic stage, with a start/done handshake.

## Interface
- WIDTH, 8, operand and sum width in bits (≥1)
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- start  input  1  request; sampled only while busy=0
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- c_in  input  1  carry-in, captured on accepted start
- busy  output  1  high while an addition is in progress (SHIFT state)
- done  output  1  one-cycle pulse: sum/c_out just updated
- sum  output  WIDTH  result register, held between operations
- c_out  output  1  final carry register, held between operations

## Operation
- States: IDLE, SHIFT, DONE.
- IDLE: busy=0, done=0. If start=1 at an edge, the edge:
  - loads a_sr←a, b_sr←b, carry←c_in, cnt←0
  - moves to SHIFT.
- SHIFT: busy=1. The full adder sees a_sr[0], b_sr[0] and carry. Each edge:
  - sum_sr←{s, sum_sr[WIDTH-1:1]}
  - carry←FA c_out
  - a_sr and b_sr shift right by one (zero fill)
  - cnt←cnt+1
- SHIFT exit: on the edge where cnt==WIDTH-1, sum←{s, sum_sr[WIDTH-1:1]} and c_out←FA c_out, and the state moves to DONE.
- DONE: done=1, busy=0. Next edge goes to IDLE, unless start=1, in which case it loads new operands as in IDLE and goes directly to SHIFT.
- start while busy=1: ignored; operands are not re-sampled.
- Result is (a+b+c_in) modulo 2^WIDTH, with bit WIDTH in c_out. No overflow flag.
- sum and c_out change only on the SHIFT→DONE edge. They are stable during SHIFT, showing the previous result.
- cnt width: clog2(WIDTH), minimum 1 bit.
- WIDTH=1: exactly one SHIFT cycle.

## Timing
- Reset values: busy=0, done=0, sum=0, c_out=0. Internal values: state=IDLE, carry=0, cnt=0, shift registers 0.
- rst has priority over every other input, including mid-SHIFT. An aborted operation never produces done, and sum/c_out return to 0.
- Start accepted at edge E0:
  - busy=1 from E0 to E0+WIDTH
  - done=1 from E0+WIDTH to E0+WIDTH+1
- Latency: WIDTH+1 cycles from start edge to end of the done pulse.
- Throughput: one addition per WIDTH+1 cycles when start is held high, since start is re-accepted in DONE.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package/header holds:
  - state encoding constants: IDLE=2'd0, SHIFT=2'd1, DONE=2'd2 (2'd3 is illegal and recovers to IDLE)
  - default WIDTH constant
- One sub-module: the existing `FA` full adder (ports a, b, c_in, s, c_out), instantiated once. No other gate-level carry logic is added.
- Everything else (FSM, counter, shift registers, output registers) lives in serial_adder.

## Test plan
- WIDTH=8, a=0x5A, b=0x33, c_in=0, start for 1 cycle -> busy high 8 cycles, then done pulse; sum=0x8D, c_out=0.
- a=0xFF, b=0x01, c_in=0 -> sum=0x00, c_out=1; then a=0xFF, b=0x00, c_in=1 -> sum=0x00, c_out=1.
- a=0x10, b=0x20 started, then at SHIFT cycle 3 drive start=1, a=0xFF, b=0xFF -> ignored; result sum=0x30, c_out=0, done exactly once.
- Start a=0xAA, b=0x55; assert rst in SHIFT cycle 4 -> next cycle busy=0, sum=0, c_out=0; no done pulse follows; a fresh start afterwards gives a correct result.
- start held high continuously with a=0x01, b=0x01 then a=0x80, b=0x80 -> done every 9 cycles; sum=0x02, c_out=0, then sum=0x00, c_out=1.
- WIDTH=1 build: a=1, b=1, c_in=1 -> busy 1 cycle, done next cycle, sum=1, c_out=1.
